// File: rtl/led_seq_player.sv
// led_seq_player: steps through a loadable DEPTH x DATA_W pattern memory on
// one-cycle button pulses and shows the selected entry on led.
// Optional feature macro: LED_SEQ_AUTOPLAY_EN adds the mode port and a tick
// counter that steps the sequence automatically every TICK_DIV clocks.
module led_seq_player #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`ifdef LED_SEQ_AUTOPLAY_EN
    input  logic              mode,
`endif
    output logic [DATA_W-1:0] led,
    output logic [ADDR_W-1:0] cur_idx,
    output logic              step_done,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    // The auto-play counter needs at least a few clocks per step so that a
    // step can finish before the next tick arrives.
    if (TICK_DIV < 4) begin : g_bad_tick_div
        $error("TICK_DIV must be at least 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_rd_en;
    logic              w_req;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_led;
    logic [ADDR_W-1:0] r_cur_idx;
    logic              r_step_done;

`ifdef LED_SEQ_AUTOPLAY_EN
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_TC = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]  r_tick_cnt;
    logic              r_pause;
    logic              w_tick;

    // Tick counter: free-runs in auto mode unless paused; button toggles
    // pause. Manual mode parks the counter at 0 and clears pause.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_pause    <= 1'b0;
        end else if (!mode) begin
            r_tick_cnt <= '0;
            r_pause    <= 1'b0;
        end else begin
            if (button)
                r_pause <= !r_pause;
            if (!r_pause)
                r_tick_cnt <= (r_tick_cnt == TICK_TC) ? '0 : r_tick_cnt + 1'b1;
        end
    end

    // A tick landing while a step is in flight is simply lost (FSM drops it).
    assign w_tick = mode && !r_pause && (r_tick_cnt == TICK_TC);
    assign w_req  = mode ? w_tick : button;
`else
    assign w_req  = button;
`endif

    // Next-state: a write owns the single RAM port, so a request that
    // collides with a write parks in PEND until the port is free.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (wr_en) begin
                        w_state_nxt = S_PEND;
                    end else begin
                        w_rd_en     = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_PEND: begin
                if (!wr_en) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Single-port pattern RAM with registered read; never cleared by reset.
    // r_dout only reloads on a read, so a write during WAIT cannot disturb
    // the word already fetched for this step.
    always_ff @(posedge clk) begin
        if (wr_en)
            r_mem[wr_addr] <= wr_data;
        else if (w_rd_en)
            r_dout <= r_mem[r_ptr];
    end

    // State, display and read pointer; reset aborts any step in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_led       <= '0;
            r_cur_idx   <= '0;
            r_step_done <= 1'b0;
            r_ptr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_step_done <= (r_state == S_WAIT);
            if (r_state == S_WAIT) begin
                r_led     <= r_dout;
                r_cur_idx <= r_ptr;
                r_ptr     <= r_ptr + 1'b1;
            end
        end
    end

    assign led       = r_led;
    assign cur_idx   = r_cur_idx;
    assign step_done = r_step_done;
    assign busy      = (r_state != S_IDLE);

endmodule
